// File: rtl/conv_window_gen_pkg.sv
// Shared types and constants for the 3x3 window generator.
package conv_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int WIN_TAPS  = 9;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // LSB position of tap k (k = row*3 + col) in the packed window bus.
  function automatic int win_lsb(input int k, input int pix_w);
    return k * pix_w;
  endfunction
endpackage

// File: rtl/conv_window_gen_line_buf.sv
// Single-port line buffer: combinational read and registered write at the same
// address, so a read in the write cycle returns the old contents.
module conv_line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 window stream (no padding).
// Optional CONV_WIN_CNT_EN adds a per-frame window counter and frame_done pulse.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sof,
  input  logic [PIX_W-1:0]          in_pix,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIN_TAPS*PIX_W-1:0] out_win
`ifdef CONV_WIN_CNT_EN
  ,
  output logic [15:0]               win_cnt,
  output logic                      frame_done
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t           r_state;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [PIX_W-1:0] r_win [3][3];

  logic             w_acc;
  logic             w_emit;
  logic             w_col_last;
  logic             w_row_last;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic [2*PIX_W-1:0] w_lb_rd;
  logic [2*PIX_W-1:0] w_lb_wr;

  assign out_valid  = (r_state == HOLD);
  assign in_ready   = !out_valid || out_ready;
  assign w_acc      = in_valid && in_ready;
  // An sof pixel is placed at (0,0) regardless of where the counters are.
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_col_last = (w_col == COL_LAST);
  assign w_row_last = (w_row == ROW_LAST);
  assign w_emit     = (w_row >= RW'(2)) && (w_col >= CW'(2));

  // Upper half holds the row before (lb1), lower half the previous row (lb0).
  assign w_lb_wr = {w_lb_rd[PIX_W-1:0], in_pix};

  conv_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (2 * PIX_W)
  ) u_lb (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (w_col),
    .i_wdata (w_lb_wr),
    .o_rdata (w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          r_win[rr][cc] <= '0;
    end else begin
      if (w_acc) begin
        r_col <= w_col_last ? '0 : w_col + 1'b1;
        if (w_col_last) r_row <= w_row_last ? '0 : w_row + 1'b1;
        else            r_row <= w_row;
        for (int rr = 0; rr < 3; rr++) begin
          r_win[rr][0] <= r_win[rr][1];
          r_win[rr][1] <= r_win[rr][2];
        end
        r_win[0][2] <= w_lb_rd[2*PIX_W-1:PIX_W];
        r_win[1][2] <= w_lb_rd[PIX_W-1:0];
        r_win[2][2] <= in_pix;
        // Accept implies the held window (if any) is consumed this cycle.
        r_state <= w_emit ? HOLD : IDLE;
      end else if (out_valid && out_ready) begin
        r_state <= IDLE;
      end
    end
  end

  for (genvar k = 0; k < WIN_TAPS; k++) begin : g_pack
    assign out_win[win_lsb(k, PIX_W) +: PIX_W] = r_win[k / 3][k % 3];
  end

`ifdef CONV_WIN_CNT_EN
  logic        w_hs;
  logic        r_last;
  logic [15:0] r_win_cnt;
  logic        r_frame_done;

  assign w_hs       = out_valid && out_ready;
  assign win_cnt    = r_win_cnt;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last       <= 1'b0;
      r_win_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_acc && w_emit) r_last <= w_row_last && w_col_last;
      r_frame_done <= w_hs && r_last;
      if (r_frame_done || (w_acc && in_sof)) r_win_cnt <= '0;
      else if (w_hs)                         r_win_cnt <= r_win_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 frame; the counter checks
// are active when CONV_WIN_CNT_EN is defined.
module tb_conv_window_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [PW-1:0] in_pix;
  logic          out_valid;
  logic          out_ready;
  logic [9*PW-1:0] out_win;
`ifdef CONV_WIN_CNT_EN
  logic [15:0]   win_cnt;
  logic          frame_done;
`endif

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win)
`ifdef CONV_WIN_CNT_EN
    ,
    .win_cnt   (win_cnt),
    .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*PW-1:0] win;
    bit              last;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rx = 0;
  int   n_fd = 0;
  int   m_col = 0;
  int   m_row = 0;
  int   img[H][W];
  bit   model_push = 1'b1;
  bit   rnd_ready = 1'b0;
  bit   fd_due = 1'b0;
  bit   zero_due = 1'b0;

  function automatic logic [9*PW-1:0] pack9(input int p[9]);
    logic [9*PW-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*PW +: PW] = p[k][PW-1:0];
    return v;
  endfunction

  task automatic model_accept(input int pix, input bit sof, output bit emit);
    int   c;
    int   r;
    int   p[9];
    exp_t e;
    c = sof ? 0 : m_col;
    r = sof ? 0 : m_row;
    img[r][c] = pix;
    emit = (r >= 2) && (c >= 2);
    if (emit && model_push) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          p[i*3+j] = img[r-2+i][c-2+j];
      e.win  = pack9(p);
      e.last = (r == H-1) && (c == W-1);
      sb.push_back(e);
    end
    if (c == W-1) begin
      m_col = 0;
      m_row = (r == H-1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
  endtask

  task automatic send(input int pix, input bit sof);
    bit acc;
    bit emit;
    int guard;
    in_valid = 1'b1;
    in_pix   = pix[PW-1:0];
    in_sof   = sof;
    acc      = 1'b0;
    emit     = 1'b0;
    guard    = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) model_accept(pix, sof, emit);
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    n_chk++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout pix=%0d not accepted within 200 cycles", pix);
    end else if (out_valid !== emit) begin
      n_fail++;
      $display("FAIL emit_latency pix=%0d out_valid=%b required=%b", pix, out_valid, emit);
    end
  endtask

  task automatic send_frame(input int base, input int n, input bit sof_first);
    for (int i = 0; i < n; i++) send(base + i, sof_first && (i == 0));
  endtask

  task automatic drain(input int rx_start, input int exp_n, input string name);
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0 || (n_rx - rx_start) != exp_n) begin
      n_fail++;
      $display("FAIL %s_count windows=%0d required=%0d pending=%0d", name, n_rx - rx_start, exp_n, sb.size());
    end
  endtask

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
`ifdef CONV_WIN_CNT_EN
    if (zero_due) begin
      n_chk++;
      if (win_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL win_cnt_clear win_cnt=%0d required=0", win_cnt);
      end
    end
    zero_due = 1'b0;
    if (fd_due) begin
      n_chk++;
      n_fd++;
      zero_due = 1'b1;
      if (frame_done !== 1'b1 || win_cnt !== 16'((W-2)*(H-2))) begin
        n_fail++;
        $display("FAIL frame_done frame_done=%b win_cnt=%0d required 1/%0d", frame_done, win_cnt, (W-2)*(H-2));
      end
    end else if (frame_done === 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_done_spurious frame_done=1 required=0");
    end
    fd_due = 1'b0;
`endif
    if (rst && out_valid && out_ready) begin
      n_chk++;
      n_rx++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_window out_win=%h required none", out_win);
      end else begin
        e_mon = sb.pop_front();
        if (out_win !== e_mon.win) begin
          n_fail++;
          $display("FAIL window out_win=%h required=%h", out_win, e_mon.win);
        end
        fd_due = e_mon.last;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_win !== '0) begin
      n_fail++;
      $display("FAIL reset out_valid=%b in_ready=%b out_win=%h required 0/1/0", out_valid, in_ready, out_win);
    end
    rst = 1'b1;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic test_basic();
    int   tbl[4][9] = '{'{1, 2, 3, 5, 6, 7, 9, 10, 11},
                        '{2, 3, 4, 6, 7, 8, 10, 11, 12},
                        '{5, 6, 7, 9, 10, 11, 13, 14, 15},
                        '{6, 7, 8, 10, 11, 12, 14, 15, 16}};
    int   p[9];
    exp_t e;
    int   s;
    s = n_rx;
    model_push = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 9; k++) p[k] = tbl[w][k];
      e.win  = pack9(p);
      e.last = (w == 3);
      sb.push_back(e);
    end
    send_frame(1, 16, 1'b1);
    drain(s, 4, "basic");
    model_push = 1'b1;
  endtask

  task automatic test_backpressure();
    int p[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    logic [9*PW-1:0] w0;
    int s;
    s  = n_rx;
    w0 = pack9(p);
    send_frame(1, 11, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pix    = 8'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_win !== w0) begin
        n_fail++;
        $display("FAIL hold cycle=%0d out_valid=%b in_ready=%b out_win=%h required 1/0/%h", i, out_valid, in_ready, out_win, w0);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_frame(12, 5, 1'b0);
    drain(s, 4, "backpressure");
  endtask

  task automatic test_back_to_back();
    int s;
    s = n_rx;
    send_frame(1, 16, 1'b1);
    send_frame(101, 16, 1'b1);
    drain(s, 8, "back_to_back");
  endtask

  task automatic test_mid_sof();
    int s;
    s = n_rx;
    send_frame(1, 6, 1'b1);
    send_frame(201, 16, 1'b1);
    drain(s, 4, "mid_sof");
  endtask

  task automatic test_reset_mid();
    int s;
    send_frame(1, 11, 1'b1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_win !== '0) begin
      n_fail++;
      $display("FAIL reset_mid out_valid=%b in_ready=%b out_win=%h required 0/1/0", out_valid, in_ready, out_win);
    end
    rst = 1'b1;
    sb.delete();
    m_col = 0;
    m_row = 0;
    out_ready = 1'b1;
    s = n_rx;
    send_frame(51, 16, 1'b0);
    drain(s, 4, "reset_mid");
  endtask

  task automatic test_random_ready();
    int s;
    int f;
    s = n_rx;
    f = n_fd;
    rnd_ready = 1'b1;
    send_frame(31, 16, 1'b1);
    drain(s, 4, "random_ready");
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
`ifdef CONV_WIN_CNT_EN
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (n_fd - f != 1) begin
      n_fail++;
      $display("FAIL frame_done_pulses pulses=%0d required=1", n_fd - f);
    end
`else
    f = f + 0;
`endif
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pix    = '0;
    out_ready = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_sof();
    test_reset_mid();
    test_random_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Upstream feeder for the 3x3 convolution accelerator. Converts a raster-order pixel stream into a stream of complete 3x3 windows, using two on-chip line buffers and a 3x3 shift register. Each emitted window is packed row-major (w0 top-left .. w8 bottom-right), which is the accelerator's window[0..8] / kernel[0..8] ordering. No padding: only windows fully inside the frame are emitted.

Parameters:
IMG_W, 32, frame width in pixels (>=3)
IMG_H, 32, frame height in pixels (>=3)
PIX_W, 8, pixel width in bits; unsigned, passed through unmodified

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  reset: synchronous, active-low (asserted when 0)
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts pixel this cycle
in_sof  in  1  start-of-frame; qualifies the accepted pixel as row 0 / col 0
in_pix  in  PIX_W  input pixel
out_valid  out  1  window valid
out_ready  in  1  consumer accepts window
out_win  out  9*PIX_W  window; w[k] at bits [k*PIX_W +: PIX_W], k=row*3+col

Behaviour:
- Accept: in_valid && in_ready. Output handshake: out_valid && out_ready.
- in_ready = !out_valid || out_ready, with combinational backpressure. No pixel is accepted while an unconsumed window is held.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1. Both advance only on accept; col wraps to 0 and increments row; the pixel at (IMG_H-1, IMG_W-1) wraps both to 0.
- in_sof on accept: that pixel is processed as (0,0), and the next pixel is (0,1), regardless of the current counters. A mid-frame sof discards the partial frame. Line-buffer contents are not cleared, but no window is emitted until row>=2 again.
- Line buffers lb0 (previous row) and lb1 (row before), each IMG_W x PIX_W. On accept at col c:
  - column {top,mid,bot} = {lb1[c], lb0[c], in_pix}
  - lb1[c] <= lb0[c]; lb0[c] <= in_pix
- Window shift register: on accept, the columns shift left and the new column enters at col 2.
- Emission: on accept with row>=2 && col>=2, out_valid is set on the next cycle, so latency is 1 cycle from accept. out_win equals the shift-register contents after the update.
- Accept without emission: out_valid is cleared. This is legal because in_ready implies the previous window was consumed.
- out_valid is held with out_win stable until the output handshake completes.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Windows never span a row wrap, because col>=2 is required.
- Reset (any cycle, including mid-frame):
  - out_valid=0, out_win=0, in_ready=1 from the next cycle
  - col=row=0, shift register = 0
  - line-buffer contents need not be cleared
- Two states: IDLE (out_valid=0) and HOLD (out_valid=1).
  - IDLE->HOLD: emitting accept.
  - HOLD->IDLE: output handshake without an emitting accept.
  - HOLD->HOLD: handshake coinciding with an emitting accept.

Optional Feature:
Macro CONV_WIN_CNT_EN.
- Defined: adds output win_cnt (16 bits) and output frame_done (1 bit).
  - win_cnt counts output handshakes in the current frame.
  - win_cnt is cleared by reset, by accepting an in_sof pixel, and on the cycle after frame_done.
  - frame_done is a 1-cycle pulse on the handshake of the last window of a frame (row=IMG_H-1, col=IMG_W-1 window).
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package conv_pkg: PIX_W default; constant WIN_TAPS=9; function/localparam for window bit offsets; state enum {IDLE, HOLD}.
- Sub-module conv_line_buf: single-port IMG_W x PIX_W buffer with one read and one write per accept at the same address (read-before-write). Instantiated twice, or once at 2*PIX_W width.

Test Plan:
1. IMG_W=IMG_H=4, pixels 1..16 streamed with out_ready=1 -> 4 windows: {1,2,3,5,6,7,9,10,11}, {2,3,4,6,7,8,10,11,12}, {5,6,7,9,10,11,13,14,15}, {6,7,8,10,11,12,14,15,16}; each window appears 1 cycle after accepting pixel 11/12/15/16.
2. Same stream, out_ready=0 for 5 cycles after the first window -> out_win held at the first window; in_ready=0; no pixel is lost; the remaining 3 windows are correct.
3. Two back-to-back 4x4 frames (second frame pixels 101..116, sof on 101) -> 8 windows; the first window of frame 2 is {101,102,103,105,106,107,109,110,111}; none mixes frames.
4. sof re-asserted at pixel 7 of frame 1, then a full 16-pixel frame follows -> no window from the partial frame; 4 correct windows from the new frame.
5. Reset driven low while out_valid=1 mid-frame -> next cycle out_valid=0 and in_ready=1; a fresh frame then yields exactly 4 correct windows.
6. With CONV_WIN_CNT_EN, random out_ready at 50% -> win_cnt reaches 4; frame_done pulses exactly once, on the 4th handshake; win_cnt=0 the following cycle.
